truth_table_scanner: RTL

- Sequential stimulus/response engine for N-input, 1-output combinational functions. This is the driving and reading end of the block-under-test interface.
- On start, it walks every input vector from 0 to 2^N_IN-1 and holds each vector for a settle window.
- It samples the function output on each vector and assembles a minterm mask plus a ones count.
- Sits beside any exercise combinational module (e.g. s = (~a|b)&(b|~c)) so truth tables are produced in hardware instead of by #1 stimulus lists.

---
 rtl/tt_pkg.sv | 18 +
 rtl/tt_settle_timer.sv | 31 +++
 rtl/truth_table_scanner.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/tt_pkg.sv
// Shared types and constants for the truth-table scanner.
// Holds the FSM state encoding, the vector-count helper and the settle counter width.
package tt_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        SAMPLE = 2'd2,
        FINISH = 2'd3
    } tt_state_e;

    localparam int SETTLE_W = 4;

    function automatic int n_vec(input int n_in);
        return 1 << n_in;
    endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// Loadable down-counter that times the hold window of each input vector.
// Priority is clear, then load, then decrement; tc is high while the count is zero.
module tt_settle_timer
    import tt_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                load,
    input  logic [SETTLE_W-1:0] load_value,
    input  logic                dec,
    output logic                tc
);

    logic [SETTLE_W-1:0] count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_value;
        end else if (dec && (count_reg != '0)) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign tc = (count_reg == '0);

endmodule

// File: rtl/truth_table_scanner.sv
// Walks every input vector of an N_IN-input function, samples its output and builds a minterm mask.
// Define TRUTH_TABLE_COMPARE_EN to add the expected-mask comparison (expected/mismatch/first_bad).
module truth_table_scanner
    import tt_pkg::*;
#(
    parameter int N_IN   = 3,
    parameter int SETTLE = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic [N_IN-1:0]        drive,
    input  logic                   resp,
    output logic                   busy,
    output logic                   done,
    output logic [(1<<N_IN)-1:0]   minterms,
`ifdef TRUTH_TABLE_COMPARE_EN
    input  logic [(1<<N_IN)-1:0]   expected,
    output logic                   mismatch,
    output logic [N_IN-1:0]        first_bad,
`endif
    output logic [N_IN:0]          ones_count
);

    localparam int N_VEC = n_vec(N_IN);
    localparam logic [N_IN-1:0] LAST_VEC = '1;

    tt_state_e            state_reg;
    tt_state_e            state_next;
    logic [N_IN-1:0]      drive_reg;
    logic [N_VEC-1:0]     minterms_reg;
    logic [N_IN:0]        ones_count_reg;
    logic                 accept;
    logic                 last_vec;
    logic                 timer_clear;
    logic                 timer_load;
    logic                 timer_dec;
    logic                 timer_tc;

    assign last_vec = (drive_reg == LAST_VEC);

    tt_settle_timer u_settle_timer (
        .clk        (clk),
        .rst        (rst),
        .clear      (timer_clear),
        .load       (timer_load),
        .load_value (SETTLE_W'(SETTLE)),
        .dec        (timer_dec),
        .tc         (timer_tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = HOLD;
            HOLD:    if (timer_tc) state_next = SAMPLE;
            SAMPLE:  state_next = last_vec ? FINISH : HOLD;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The timer is reloaded whenever a new vector starts its hold window.
    always_comb begin
        accept      = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        timer_clear = 1'b0;
        timer_load  = 1'b0;
        timer_dec   = 1'b0;
        case (state_reg)
            IDLE: begin
                accept     = start;
                timer_load = start;
            end
            HOLD: begin
                busy      = 1'b1;
                timer_dec = !timer_tc;
            end
            SAMPLE: begin
                busy       = 1'b1;
                timer_load = !last_vec;
            end
            FINISH: begin
                done        = 1'b1;
                timer_clear = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drive_reg      <= '0;
            minterms_reg   <= '0;
            ones_count_reg <= '0;
        end else if (accept) begin
            drive_reg      <= '0;
            minterms_reg   <= '0;
            ones_count_reg <= '0;
        end else if (state_reg == SAMPLE) begin
            minterms_reg[drive_reg] <= resp;
            ones_count_reg          <= ones_count_reg + (N_IN+1)'(resp);
            if (!last_vec) begin
                drive_reg <= drive_reg + 1'b1;
            end
        end else if (state_reg == FINISH) begin
            drive_reg <= '0;
        end
    end

`ifdef TRUTH_TABLE_COMPARE_EN
    logic [N_VEC-1:0] expected_reg;
    logic             mismatch_reg;
    logic [N_IN-1:0]  first_bad_reg;

    // first_bad latches only while mismatch is still clear, i.e. the first miss of the scan.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            expected_reg  <= '0;
            mismatch_reg  <= 1'b0;
            first_bad_reg <= '0;
        end else if (accept) begin
            expected_reg  <= expected;
            mismatch_reg  <= 1'b0;
            first_bad_reg <= '0;
        end else if ((state_reg == SAMPLE) && (resp != expected_reg[drive_reg])) begin
            mismatch_reg <= 1'b1;
            if (!mismatch_reg) begin
                first_bad_reg <= drive_reg;
            end
        end
    end

    assign mismatch  = mismatch_reg;
    assign first_bad = first_bad_reg;
`endif

    assign drive      = drive_reg;
    assign minterms   = minterms_reg;
    assign ones_count = ones_count_reg;

endmodule
